// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data RAM behind a one-outstanding load/store port.
// Latency: a request accepted at edge E0 commits and presents its response at edge E0+1+WAIT_CYCLES.
// Backpressure: req_ready is low from accept until the response handshake edge; the response holds until rsp_ready.
//
// Ports:
//   clk, res_n                  clock, asynchronous active-low reset
//   req_valid / req_ready       request handshake (req_ready decoded from state only)
//   req_write, req_size,        store/load, 00 byte / 01 half / 10,11 word,
//   req_unsigned, req_addr,     zero-extend loads, byte address,
//   req_wdata                   right-justified store data
//   rsp_valid / rsp_ready       response handshake (rsp_valid decoded from state only)
//   rsp_rdata, rsp_err          extended load data (0 for stores), misalignment flag
//
// Optional feature: define DMEM_MISALIGN_TRAP_EN to flag misaligned half/word accesses
// with rsp_err = 1, rsp_rdata = 0 and no RAM write. Without it, misaligned accesses are
// force-aligned and rsp_err is tied to 0.

module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        res_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  logic [3:0]  cnt_nxt;
  logic        accept;
  logic        commit;

  // Request captured on the accept edge; later input changes are ignored.
  logic        lat_write;
  logic [1:0]  lat_size;
  logic        lat_unsigned;
  logic [AW+1:0] lat_addr;
  logic [31:0] lat_wdata;

  logic [31:0] mem [DEPTH_WORDS];

  // Address bits above the RAM range wrap and are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:AW+2];

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept    = 1'b1;
          cnt_nxt   = 4'(WAIT_CYCLES);
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          commit    = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  // ---------------------------------------------------------------------------
  // Request capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      lat_write    <= 1'b0;
      lat_size     <= 2'b00;
      lat_unsigned <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= 32'd0;
    end else if (accept) begin
      lat_write    <= req_write;
      lat_size     <= req_size;
      lat_unsigned <= req_unsigned;
      lat_addr     <= req_addr[AW+1:0];
      lat_wdata    <= req_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Access decode
  // ---------------------------------------------------------------------------
  logic [AW-1:0] word_idx;
  logic [1:0]    byte_off;
  logic          is_half;
  logic          is_word;
  logic          trap;
  logic [3:0]    lane_mask;
  logic [3:0]    wr_lanes;
  logic [31:0]   wr_word;
  logic [31:0]   rd_word;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   load_ext;
  logic [31:0]   rdata_nxt;

  assign word_idx = lat_addr[AW+1:2];
  assign byte_off = lat_addr[1:0];
  assign is_half  = (lat_size == 2'b01);
  assign is_word  = lat_size[1];

`ifdef DMEM_MISALIGN_TRAP_EN
  assign trap = (is_half & byte_off[0]) | (is_word & (byte_off != 2'b00));
`else
  assign trap = 1'b0;
`endif

  always_comb begin
    // Lane selection ignores the low offset bits a half/word cannot use, which
    // is exactly the force-align behaviour when misaligned accesses are not trapped.
    lane_mask = 4'b0000;
    wr_word   = lat_wdata;
    if (is_word) begin
      lane_mask = 4'b1111;
      wr_word   = lat_wdata;
    end else if (is_half) begin
      lane_mask = byte_off[1] ? 4'b1100 : 4'b0011;
      wr_word   = {2{lat_wdata[15:0]}};
    end else begin
      lane_mask = 4'b0001 << byte_off;
      wr_word   = {4{lat_wdata[7:0]}};
    end
  end

  assign wr_lanes = (commit && lat_write && !trap) ? lane_mask : 4'b0000;

  always_comb begin
    rd_word  = mem[word_idx];
    byte_sel = 8'(rd_word >> {byte_off, 3'b000});
    half_sel = byte_off[1] ? rd_word[31:16] : rd_word[15:0];
    load_ext = rd_word;
    if (is_word) begin
      load_ext = rd_word;
    end else if (is_half) begin
      load_ext = {{16{~lat_unsigned & half_sel[15]}}, half_sel};
    end else begin
      load_ext = {{24{~lat_unsigned & byte_sel[7]}}, byte_sel};
    end
    rdata_nxt = (lat_write || trap) ? 32'd0 : load_ext;
  end

  // ---------------------------------------------------------------------------
  // RAM: contents are not reset. A store only lands on its commit edge, so a
  // reset while in ACCESS leaves the RAM untouched.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_lanes[i]) begin
        mem[word_idx][8*i +: 8] <= wr_word[8*i +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response registers: loaded on the commit edge, held through RESP.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      rsp_rdata <= 32'd0;
    end else if (commit) begin
      rsp_rdata <= rdata_nxt;
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  logic err_q;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      err_q <= 1'b0;
    end else if (commit) begin
      err_q <= trap;
    end
  end

  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: byte-array reference model fed by the observed
// request handshake, one negedge compare process, plus literal directed checks.
module tb_dmem_responder;

  localparam int D = 64;
  localparam int W = 3;

  logic        clk = 1'b0;
  logic        res_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(D), .WAIT_CYCLES(W)) dut (
    .clk(clk),
    .res_n(res_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_size(req_size),
    .req_unsigned(req_unsigned),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: RAM as a flat byte array, little-endian.
  // phase 0 = idle, 1 = request outstanding, 2 = response presented.
  // ---------------------------------------------------------------------------
  logic [7:0]  bmem [4*D];
  int          phase = 0;
  int          edge_n = 0;
  int          acc_n = 0;
  logic        m_write = 1'b0;
  logic [1:0]  m_size = 2'b00;
  logic        m_uns = 1'b0;
  logic [31:0] m_addr = 32'd0;
  logic [31:0] m_wdata = 32'd0;
  logic [31:0] exp_rd = 32'd0;
  logic        exp_err = 1'b0;

  task automatic model_access();
    int a;
    int n;
    int base;
    logic [31:0] v;
    a = int'(m_addr % 32'(4*D));
    n = (m_size == 2'b00) ? 1 : (m_size == 2'b01) ? 2 : 4;
    base = a - (a % n);
    exp_rd = 32'd0;
    exp_err = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    if ((a % n) != 0) begin
      exp_err = 1'b1;
      return;
    end
`endif
    if (m_write) begin
      for (int k = 0; k < n; k++) bmem[base+k] = m_wdata[8*k +: 8];
    end else begin
      v = 32'd0;
      for (int k = 0; k < n; k++) v = v | (32'(bmem[base+k]) << (8*k));
      if (n < 4 && !m_uns && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      exp_rd = v;
    end
  endtask

  always @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      phase = 0;
    end else begin
      edge_n++;
      case (phase)
        0: if (req_valid) begin
          m_write = req_write;
          m_size  = req_size;
          m_uns   = req_unsigned;
          m_addr  = req_addr;
          m_wdata = req_wdata;
          acc_n   = edge_n;
          phase   = 1;
        end
        1: if (edge_n == acc_n + 1 + W) begin
          model_access();
          phase = 2;
        end
        2: if (rsp_ready) phase = 0;
        default: phase = 0;
      endcase
    end
  end

  // Compare process: handshake outputs every cycle, payload whenever a response is due.
  always @(negedge clk) begin
    chk("req_ready", 32'(req_ready), 32'(phase == 0));
    chk("rsp_valid", 32'(rsp_valid), 32'(phase == 2));
    if (phase == 2) begin
      chk("rsp_rdata", rsp_rdata, exp_rd);
      chk("rsp_err", 32'(rsp_err), 32'(exp_err));
    end
  end

  // ---------------------------------------------------------------------------
  // Driver: called at posedge+1 with the DUT idle; returns to the same point.
  // ---------------------------------------------------------------------------
  task automatic xact(input logic w, input logic [1:0] sz, input logic u,
                      input logic [31:0] a, input logic [31:0] wd, input int hold,
                      output logic [31:0] rd, output logic er, output int lat);
    req_valid = 1'b1;
    req_write = w;
    req_size = sz;
    req_unsigned = u;
    req_addr = a;
    req_wdata = wd;
    @(posedge clk); #1;
    // Scramble the request and wiggle req_valid: nothing may be taken while busy.
    req_valid = 1'($urandom_range(0, 1));
    req_write = 1'($urandom);
    req_size = 2'($urandom);
    req_unsigned = 1'($urandom);
    req_addr = $urandom;
    req_wdata = $urandom;
    lat = 0;
    while (!rsp_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("rsp_arrived", 32'(rsp_valid), 32'd1);
    rd = rsp_rdata;
    er = rsp_err;
    repeat (hold) begin
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;

  initial begin
    #1 res_n = 1'b0;
    #11;
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    #10 res_n = 1'b1;
    @(posedge clk); #1;

    // Fill every word so the model knows the whole RAM.
    for (int i = 0; i < D; i++) begin
      xact(1'b1, 2'b10, 1'b0, 32'(4*i), $urandom, 0, rd, er, lat);
    end

    // Word store then byte loads; also pins accept-to-response latency.
    xact(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 0, rd, er, lat);
    chk("store_latency", 32'(lat), 32'd4);
    chk("store_rdata_zero", rd, 32'd0);
    xact(1'b0, 2'b00, 1'b1, 32'h13, 32'd0, 0, rd, er, lat);
    chk("lbu_0x13", rd, 32'h000000DE);
    xact(1'b0, 2'b00, 1'b0, 32'h12, 32'd0, 5, rd, er, lat);
    chk("lb_0x12", rd, 32'hFFFFFFAD);
    chk("load_latency", 32'(lat), 32'd4);

    // Halfword merge into an existing word.
    xact(1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, 0, rd, er, lat);
    xact(1'b1, 2'b01, 1'b0, 32'h22, 32'h00008001, 0, rd, er, lat);
    xact(1'b0, 2'b10, 1'b0, 32'h20, 32'd0, 2, rd, er, lat);
    chk("lw_0x20", rd, 32'h80013344);
    xact(1'b0, 2'b01, 1'b0, 32'h22, 32'd0, 0, rd, er, lat);
    chk("lh_0x22", rd, 32'hFFFF8001);

    // Misaligned word load.
    xact(1'b1, 2'b10, 1'b0, 32'h04, 32'h0A0B0C0D, 0, rd, er, lat);
    xact(1'b0, 2'b10, 1'b0, 32'h06, 32'd0, 0, rd, er, lat);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk("misalign_rdata", rd, 32'd0);
    chk("misalign_err", 32'(er), 32'd1);
`else
    chk("misalign_rdata", rd, 32'h0A0B0C0D);
    chk("misalign_err", 32'(er), 32'd0);
`endif

    // Reset in the middle of a store's wait states.
    xact(1'b1, 2'b10, 1'b0, 32'h40, 32'h00000000, 0, rd, er, lat);
    xact(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 0, rd, er, lat);
    chk("lw_0x10", rd, 32'hDEADBEEF);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_size = 2'b10;
    req_unsigned = 1'b0;
    req_addr = 32'h40;
    req_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    res_n = 1'b0;
    #1;
    chk("midreset_req_ready", 32'(req_ready), 32'd1);
    chk("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midreset_rsp_rdata", rsp_rdata, 32'd0);
    @(posedge clk); #1;
    res_n = 1'b1;
    xact(1'b0, 2'b10, 1'b0, 32'h40, 32'd0, 0, rd, er, lat);
    chk("lw_0x40_after_reset", rd, 32'h00000000);

    // Address wrap.
    xact(1'b1, 2'b10, 1'b0, 32'(4*D + 8), 32'h12345678, 0, rd, er, lat);
    xact(1'b0, 2'b10, 1'b0, 32'h08, 32'd0, 0, rd, er, lat);
    chk("alias_0x8", rd, 32'h12345678);

    // Randomised traffic against the model.
    for (int i = 0; i < 250; i++) begin
      xact(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom,
           int'($urandom_range(0, 3)), rd, er, lat);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the RISC-V pipeline: the slave end of the load/store interface driven by the MEM stage. Accepts one request at a time through a valid/ready handshake, holds it for a configurable number of wait states, and commits stores with byte-lane masking. Returns sign- or zero-extended load data through a valid/ready response channel. Owns the word-organised data RAM.

## Interface
Parameters:
- DEPTH_WORDS, 1024: RAM size in 32-bit words; power of two. AW = log2(DEPTH_WORDS).
- WAIT_CYCLES, 1: extra access cycles, 0..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- res_n  in  1  reset; asynchronous assert, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word; 11 is treated as word.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  MEM stage takes the response.
- rsp_rdata  out  32  extended load data; 0 for stores.
- rsp_err  out  1  misaligned access (only when DMEM_MISALIGN_TRAP_EN is defined).

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: req_ready = 1. When req_valid = 1 on an edge, latch write/size/unsigned/addr/wdata, load wait counter with WAIT_CYCLES, go to ACCESS.
- ACCESS: req_ready = 0. Counter ≠ 0: decrement. Counter = 0: perform access on this edge, load rsp_rdata/rsp_err, go to RESP.
- RESP: rsp_valid = 1; rsp_rdata/rsp_err are stable. When rsp_ready = 1 on an edge, go to IDLE. rsp_valid and req_ready are never high together.
- Word index = addr[AW+1:2]. Upper address bits are ignored, so addresses wrap modulo 4*DEPTH_WORDS.
- Store lanes:
  - byte: lane addr[1:0] gets wdata[7:0].
  - half: lanes {addr[1],0} and {addr[1],1} get wdata[15:0].
  - word: all four lanes.
  - Unselected lanes are unchanged.
- Load data:
  - byte: lane addr[1:0], extended to 32 bits.
  - half: halfword addr[1], extended to 32 bits.
  - word: the raw word.
- Misaligned access: half with addr[0] = 1, or word with addr[1:0] ≠ 0. Handling depends on Configuration.
- Reset: state goes to IDLE, counter to 0, rsp_rdata to 0, rsp_err to 0, so rsp_valid = 0 and req_ready = 1. RAM contents are not reset.
- Reset during ACCESS drops the request; a store whose commit edge has not occurred leaves the RAM unchanged. Reset during RESP discards the response.

## Timing
- A request accepted at edge E0 commits at edge E0 + 1 + WAIT_CYCLES. rsp_valid is high from that edge onward.
- Minimum turnaround is WAIT_CYCLES + 3 edges per transaction: accept, access, and the response handshake. No new request is accepted before the response edge returns the block to IDLE.
- Request inputs are sampled only on the accept edge; changes afterwards are ignored.
- req_ready and rsp_valid are decoded from state only, with no combinational path from any input.

## Configuration
- DMEM_MISALIGN_TRAP_EN defined:
  - A misaligned access returns rsp_err = 1 and rsp_rdata = 0.
  - A misaligned store writes nothing.
  - Latency is unchanged.
- DMEM_MISALIGN_TRAP_EN undefined:
  - rsp_err is tied to 0.
  - Misaligned addresses are force-aligned (half clears addr[0]; word clears addr[1:0]) and the access completes normally.

## Test plan
- Store word 0xDEADBEEF to 0x10, then load byte unsigned at 0x13 -> rsp_rdata 0x000000DE. Load byte signed at 0x12 -> 0xFFFFFFAD.
- Store half 0x8001 to 0x22 over a word holding 0x11223344, then load word at 0x20 -> 0x80013344. Load half signed at 0x22 -> 0xFFFF8001.
- WAIT_CYCLES = 3, accept at edge 10 -> rsp_valid rises after edge 14. With rsp_ready held low for 5 cycles, data stays stable and req_ready stays 0.
- Misaligned load word at 0x06:
  - with the macro: rsp_err 1, rsp_rdata 0.
  - without the macro: returns the word at 0x04, rsp_err 0.
- Assert res_n = 0 in ACCESS of a store of 0xCAFEF00D to 0x40 (written word previously 0x0) -> outputs reset immediately; a later load at 0x40 returns 0x00000000.
- Address 4*DEPTH_WORDS + 8 aliases 0x8: a store there is read back at 0x8.
